// File: rtl/acc_llbit_file.sv
`default_nettype none
// =============================================================================
// acc_llbit_file: HI/LO accumulator file with MEM/WB read forwarding, plus an
// LLbit link monitor that tracks a granule-aligned link address.
// Revision: 1.0
// =============================================================================
module acc_llbit_file #(
    parameter int NUM_ACC = 4,
    parameter int ADDR_W  = 32,
    parameter int LL_GRAN = 4,
    parameter int SEL_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wb_hl_wen_i,
    input  logic [SEL_W-1:0]  wb_hl_sel_i,
    input  logic [63:0]       wb_hl_wdata_i,
    input  logic [1:0]        mem_hl_wen_i,
    input  logic [SEL_W-1:0]  mem_hl_sel_i,
    input  logic [63:0]       mem_hl_wdata_i,
    input  logic [SEL_W-1:0]  rd_sel_i,
    output logic [63:0]       rd_data_o,
    input  logic              eret_i,
    input  logic              exc_flush_i,
    input  logic              ll_set_i,
    input  logic [ADDR_W-1:0] ll_addr_i,
    input  logic              sc_done_i,
    input  logic              snoop_wen_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
    input  logic              mem_llb_wen_i,
    input  logic              mem_llbit_i,
    output logic              llb_rdata_o,
    output logic [ADDR_W-1:0] lladdr_rdata_o
);

    logic [63:0]       acc_q [NUM_ACC];
    logic [63:0]       acc_d [NUM_ACC];
    logic              llbit_q;
    logic              llbit_d;
    logic [ADDR_W-1:0] lladdr_q;
    logic [ADDR_W-1:0] lladdr_d;

    logic [63:0]       w_rd_stored;
    logic              w_snoop_hit;

    // Selects outside 0..NUM_ACC-1 match no entry, so writes drop and reads give 0.
    always_comb begin
        for (int i = 0; i < NUM_ACC; i++) begin
            acc_d[i] = acc_q[i];
            if (wb_hl_sel_i == SEL_W'(i)) begin
                if (wb_hl_wen_i[1]) acc_d[i][63:32] = wb_hl_wdata_i[63:32];
                if (wb_hl_wen_i[0]) acc_d[i][31:0]  = wb_hl_wdata_i[31:0];
            end
        end
    end

    assign w_snoop_hit = snoop_wen_i && llbit_q &&
                         (snoop_addr_i[ADDR_W-1:LL_GRAN] == lladdr_q[ADDR_W-1:LL_GRAN]);

    always_comb begin
        llbit_d  = llbit_q;
        lladdr_d = lladdr_q;
        if (eret_i || exc_flush_i) begin
            llbit_d = 1'b0;
        end else if (ll_set_i) begin
            llbit_d  = 1'b1;
            lladdr_d = ll_addr_i;
        end else if (sc_done_i) begin
            llbit_d = 1'b0;
        end else if (w_snoop_hit) begin
            llbit_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                acc_q[i] <= '0;
            end
            llbit_q  <= 1'b0;
            lladdr_q <= '0;
        end else begin
            acc_q    <= acc_d;
            llbit_q  <= llbit_d;
            lladdr_q <= lladdr_d;
        end
    end

    // Half-wise forwarding: stored value, overridden by WB, overridden by MEM.
    always_comb begin
        w_rd_stored = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (rd_sel_i == SEL_W'(i)) w_rd_stored = acc_q[i];
        end
        if (rst) w_rd_stored = '0;

        rd_data_o = w_rd_stored;
        if (wb_hl_wen_i[1] && (wb_hl_sel_i == rd_sel_i))
            rd_data_o[63:32] = wb_hl_wdata_i[63:32];
        if (wb_hl_wen_i[0] && (wb_hl_sel_i == rd_sel_i))
            rd_data_o[31:0] = wb_hl_wdata_i[31:0];
        if (mem_hl_wen_i[1] && (mem_hl_sel_i == rd_sel_i))
            rd_data_o[63:32] = mem_hl_wdata_i[63:32];
        if (mem_hl_wen_i[0] && (mem_hl_sel_i == rd_sel_i))
            rd_data_o[31:0] = mem_hl_wdata_i[31:0];
    end

    // Snoop clears are deliberately not forwarded; they appear next cycle.
    always_comb begin
        if (mem_llb_wen_i)              llb_rdata_o = mem_llbit_i;
        else if (rst)                   llb_rdata_o = 1'b0;
        else if (eret_i || exc_flush_i) llb_rdata_o = 1'b0;
        else if (ll_set_i)              llb_rdata_o = 1'b1;
        else if (sc_done_i)             llb_rdata_o = 1'b0;
        else                            llb_rdata_o = llbit_q;
    end

    assign lladdr_rdata_o = rst ? '0 : lladdr_q;

endmodule
`default_nettype wire

// File: tb/tb_acc_llbit_file.sv
`default_nettype none
// =============================================================================
// tb_acc_llbit_file: directed self-checking bench for acc_llbit_file.
// Revision: 1.0
// =============================================================================
module tb_acc_llbit_file;

    localparam int c_SEL_W  = 2;
    localparam int c_ADDR_W = 32;

    logic                clk;
    logic                rst;
    logic [1:0]          wb_hl_wen;
    logic [c_SEL_W-1:0]  wb_hl_sel;
    logic [63:0]         wb_hl_wdata;
    logic [1:0]          mem_hl_wen;
    logic [c_SEL_W-1:0]  mem_hl_sel;
    logic [63:0]         mem_hl_wdata;
    logic [c_SEL_W-1:0]  rd_sel;
    logic [63:0]         rd_data;
    logic                eret;
    logic                exc_flush;
    logic                ll_set;
    logic [c_ADDR_W-1:0] ll_addr;
    logic                sc_done;
    logic                snoop_wen;
    logic [c_ADDR_W-1:0] snoop_addr;
    logic                mem_llb_wen;
    logic                mem_llbit;
    logic                llb_rdata;
    logic [c_ADDR_W-1:0] lladdr_rdata;

    int checks;
    int failures;

    acc_llbit_file #(
        .NUM_ACC (4),
        .ADDR_W  (32),
        .LL_GRAN (4)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .wb_hl_wen_i    (wb_hl_wen),
        .wb_hl_sel_i    (wb_hl_sel),
        .wb_hl_wdata_i  (wb_hl_wdata),
        .mem_hl_wen_i   (mem_hl_wen),
        .mem_hl_sel_i   (mem_hl_sel),
        .mem_hl_wdata_i (mem_hl_wdata),
        .rd_sel_i       (rd_sel),
        .rd_data_o      (rd_data),
        .eret_i         (eret),
        .exc_flush_i    (exc_flush),
        .ll_set_i       (ll_set),
        .ll_addr_i      (ll_addr),
        .sc_done_i      (sc_done),
        .snoop_wen_i    (snoop_wen),
        .snoop_addr_i   (snoop_addr),
        .mem_llb_wen_i  (mem_llb_wen),
        .mem_llbit_i    (mem_llbit),
        .llb_rdata_o    (llb_rdata),
        .lladdr_rdata_o (lladdr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        wb_hl_wen   = 2'b00;
        mem_hl_wen  = 2'b00;
        eret        = 1'b0;
        exc_flush   = 1'b0;
        ll_set      = 1'b0;
        sc_done     = 1'b0;
        snoop_wen   = 1'b0;
        mem_llb_wen = 1'b0;
        mem_llbit   = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        wb_hl_wen   = 2'b11;
        wb_hl_sel   = 2'd0;
        wb_hl_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        ll_set      = 1'b1;
        ll_addr     = 32'hFFFF_0000;
        tick();
        clear_strobes();
        rd_sel = 2'd0;
        #1;
        checks++;
        if (rd_data !== 64'h0) begin
            failures++;
            $display("FAIL reset_rd: got %h expected %h", rd_data, 64'h0);
        end
        checks++;
        if (llb_rdata !== 1'b0) begin
            failures++;
            $display("FAIL reset_llb: got %b expected 0", llb_rdata);
        end
        checks++;
        if (lladdr_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_lladdr: got %h expected 0", lladdr_rdata);
        end
        mem_hl_wen   = 2'b11;
        mem_hl_sel   = 2'd1;
        mem_hl_wdata = 64'h0123_4567_89AB_CDEF;
        rd_sel       = 2'd1;
        mem_llb_wen  = 1'b1;
        mem_llbit    = 1'b1;
        #1;
        checks++;
        if (rd_data !== 64'h0123_4567_89AB_CDEF) begin
            failures++;
            $display("FAIL reset_bypass_rd: got %h expected %h", rd_data, 64'h0123_4567_89AB_CDEF);
        end
        checks++;
        if (llb_rdata !== 1'b1) begin
            failures++;
            $display("FAIL reset_bypass_llb: got %b expected 1", llb_rdata);
        end
        clear_strobes();
        tick();
        rst    = 1'b0;
        rd_sel = 2'd0;
        #1;
        checks++;
        if (rd_data !== 64'h0) begin
            failures++;
            $display("FAIL reset_discard_wr: got %h expected %h", rd_data, 64'h0);
        end
        checks++;
        if (llb_rdata !== 1'b0 || lladdr_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_discard_ll: got llb=%b lladdr=%h expected llb=0 lladdr=0",
                     llb_rdata, lladdr_rdata);
        end
    endtask

    task automatic test_write();
        wb_hl_wen   = 2'b11;
        wb_hl_sel   = 2'd2;
        wb_hl_wdata = 64'h1111_1111_2222_2222;
        rd_sel      = 2'd2;
        #1;
        checks++;
        if (rd_data !== 64'h1111_1111_2222_2222) begin
            failures++;
            $display("FAIL wb_bypass: got %h expected %h", rd_data, 64'h1111_1111_2222_2222);
        end
        tick();
        clear_strobes();
        #1;
        checks++;
        if (rd_data !== 64'h1111_1111_2222_2222) begin
            failures++;
            $display("FAIL write_ac2: got %h expected %h", rd_data, 64'h1111_1111_2222_2222);
        end
        for (int s = 0; s < 4; s++) begin
            if (s != 2) begin
                rd_sel = 2'(s);
                #1;
                checks++;
                if (rd_data !== 64'h0) begin
                    failures++;
                    $display("FAIL write_other_ac%0d: got %h expected %h", s, rd_data, 64'h0);
                end
            end
        end
    endtask

    task automatic test_half_write();
        wb_hl_wen   = 2'b11;
        wb_hl_sel   = 2'd1;
        wb_hl_wdata = 64'hAAAA_AAAA_BBBB_BBBB;
        tick();
        wb_hl_wen   = 2'b10;
        wb_hl_wdata = 64'hCCCC_CCCC_DEAD_BEEF;
        tick();
        clear_strobes();
        rd_sel = 2'd1;
        #1;
        checks++;
        if (rd_data !== 64'hCCCC_CCCC_BBBB_BBBB) begin
            failures++;
            $display("FAIL half_hi: got %h expected %h", rd_data, 64'hCCCC_CCCC_BBBB_BBBB);
        end
        wb_hl_wen   = 2'b01;
        wb_hl_wdata = 64'h9999_9999_1234_5678;
        tick();
        clear_strobes();
        #1;
        checks++;
        if (rd_data !== 64'hCCCC_CCCC_1234_5678) begin
            failures++;
            $display("FAIL half_lo: got %h expected %h", rd_data, 64'hCCCC_CCCC_1234_5678);
        end
    endtask

    task automatic test_bypass();
        wb_hl_wen    = 2'b11;
        wb_hl_sel    = 2'd3;
        wb_hl_wdata  = 64'h0000_0001_0000_0001;
        mem_hl_wen   = 2'b01;
        mem_hl_sel   = 2'd3;
        mem_hl_wdata = 64'hFFFF_FFFF_0000_0005;
        rd_sel       = 2'd3;
        #1;
        checks++;
        if (rd_data !== 64'h0000_0001_0000_0005) begin
            failures++;
            $display("FAIL bypass_mem_over_wb: got %h expected %h", rd_data, 64'h0000_0001_0000_0005);
        end
        rd_sel = 2'd2;
        #1;
        checks++;
        if (rd_data !== 64'h1111_1111_2222_2222) begin
            failures++;
            $display("FAIL bypass_other_sel: got %h expected %h", rd_data, 64'h1111_1111_2222_2222);
        end
        tick();
        clear_strobes();
        rd_sel = 2'd3;
        #1;
        checks++;
        if (rd_data !== 64'h0000_0001_0000_0001) begin
            failures++;
            $display("FAIL bypass_not_stored: got %h expected %h", rd_data, 64'h0000_0001_0000_0001);
        end
    endtask

    task automatic test_ll_snoop();
        ll_set  = 1'b1;
        ll_addr = 32'h8000_1234;
        #1;
        checks++;
        if (llb_rdata !== 1'b1) begin
            failures++;
            $display("FAIL ll_fwd: got %b expected 1", llb_rdata);
        end
        tick();
        clear_strobes();
        #1;
        checks++;
        if (llb_rdata !== 1'b1 || lladdr_rdata !== 32'h8000_1234) begin
            failures++;
            $display("FAIL ll_stored: got llb=%b lladdr=%h expected llb=1 lladdr=80001234",
                     llb_rdata, lladdr_rdata);
        end
        snoop_wen  = 1'b1;
        snoop_addr = 32'h8000_123C;
        #1;
        checks++;
        if (llb_rdata !== 1'b1) begin
            failures++;
            $display("FAIL snoop_not_fwd: got %b expected 1", llb_rdata);
        end
        tick();
        clear_strobes();
        #1;
        checks++;
        if (llb_rdata !== 1'b0) begin
            failures++;
            $display("FAIL snoop_hit: got %b expected 0", llb_rdata);
        end
        ll_set  = 1'b1;
        ll_addr = 32'h8000_1234;
        tick();
        clear_strobes();
        snoop_wen  = 1'b1;
        snoop_addr = 32'h8000_1240;
        tick();
        clear_strobes();
        #1;
        checks++;
        if (llb_rdata !== 1'b1) begin
            failures++;
            $display("FAIL snoop_miss: got %b expected 1", llb_rdata);
        end
        sc_done = 1'b1;
        #1;
        checks++;
        if (llb_rdata !== 1'b0) begin
            failures++;
            $display("FAIL sc_fwd: got %b expected 0", llb_rdata);
        end
        tick();
        clear_strobes();
        #1;
        checks++;
        if (llb_rdata !== 1'b0) begin
            failures++;
            $display("FAIL sc_stored: got %b expected 0", llb_rdata);
        end
        // LL wins over a same-cycle snoop that hits the old link address.
        ll_set     = 1'b1;
        ll_addr    = 32'h0000_5000;
        snoop_wen  = 1'b1;
        snoop_addr = 32'h8000_1230;
        tick();
        clear_strobes();
        #1;
        checks++;
        if (llb_rdata !== 1'b1 || lladdr_rdata !== 32'h0000_5000) begin
            failures++;
            $display("FAIL ll_with_snoop: got llb=%b lladdr=%h expected llb=1 lladdr=00005000",
                     llb_rdata, lladdr_rdata);
        end
    endtask

    task automatic test_ll_eret();
        ll_set  = 1'b1;
        ll_addr = 32'h1234_5670;
        eret    = 1'b1;
        #1;
        checks++;
        if (llb_rdata !== 1'b0) begin
            failures++;
            $display("FAIL ll_eret_fwd: got %b expected 0", llb_rdata);
        end
        tick();
        clear_strobes();
        #1;
        checks++;
        if (llb_rdata !== 1'b0 || lladdr_rdata !== 32'h0000_5000) begin
            failures++;
            $display("FAIL ll_eret_stored: got llb=%b lladdr=%h expected llb=0 lladdr=00005000",
                     llb_rdata, lladdr_rdata);
        end
        ll_set  = 1'b1;
        ll_addr = 32'h0000_6000;
        tick();
        clear_strobes();
        exc_flush = 1'b1;
        tick();
        clear_strobes();
        #1;
        checks++;
        if (llb_rdata !== 1'b0 || lladdr_rdata !== 32'h0000_6000) begin
            failures++;
            $display("FAIL exc_clear: got llb=%b lladdr=%h expected llb=0 lladdr=00006000",
                     llb_rdata, lladdr_rdata);
        end
    endtask

    task automatic test_mem_llb();
        mem_llb_wen = 1'b1;
        mem_llbit   = 1'b1;
        eret        = 1'b1;
        #1;
        checks++;
        if (llb_rdata !== 1'b1) begin
            failures++;
            $display("FAIL mem_llb_fwd: got %b expected 1", llb_rdata);
        end
        tick();
        clear_strobes();
        #1;
        checks++;
        if (llb_rdata !== 1'b0) begin
            failures++;
            $display("FAIL mem_llb_not_stored: got %b expected 0", llb_rdata);
        end
    endtask

    task automatic test_back_to_back();
        wb_hl_wen   = 2'b11;
        wb_hl_sel   = 2'd0;
        wb_hl_wdata = 64'h0000_00A0_0000_00B0;
        tick();
        wb_hl_wdata = 64'h0000_00A1_0000_00B1;
        rd_sel      = 2'd0;
        #1;
        checks++;
        if (rd_data !== 64'h0000_00A1_0000_00B1) begin
            failures++;
            $display("FAIL b2b_bypass: got %h expected %h", rd_data, 64'h0000_00A1_0000_00B1);
        end
        wb_hl_wen = 2'b00;
        #1;
        checks++;
        if (rd_data !== 64'h0000_00A0_0000_00B0) begin
            failures++;
            $display("FAIL b2b_first: got %h expected %h", rd_data, 64'h0000_00A0_0000_00B0);
        end
        wb_hl_wen = 2'b11;
        tick();
        clear_strobes();
        #1;
        checks++;
        if (rd_data !== 64'h0000_00A1_0000_00B1) begin
            failures++;
            $display("FAIL b2b_second: got %h expected %h", rd_data, 64'h0000_00A1_0000_00B1);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        wb_hl_sel    = '0;
        wb_hl_wdata  = '0;
        mem_hl_sel   = '0;
        mem_hl_wdata = '0;
        rd_sel       = '0;
        ll_addr      = '0;
        snoop_addr   = '0;
        clear_strobes();
        tick();

        test_reset();
        test_write();
        test_half_write();
        test_bypass();
        test_ll_snoop();
        test_ll_eret();
        test_mem_llb();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
